// File: rtl/adc_scan_uart_tx_if.sv
// adc_scan_uart_tx_if
// Bundles every non-clock signal of the ADC scan sequencer / serial transmitter.
//   master : the sequencer side (drives soc, load_dato, mux_en, canale,
//            data_out, error, busy and the two FSM debug buses)
//   slave  : the ADC / line-receiver side (drives eoc, data_in, dsr)
// Handshakes:
//   - soc is a one-cycle request. The ADC answers with eoc=1 while data_in is
//     valid. The sample is taken on the first rising edge that sees eoc=1.
//   - dsr is a level "receiver ready". It is sampled once, on the cycle a
//     frame would start. It is not re-checked while the frame is shifting.
// Debug: scan_state / tx_state mirror the two FSM state registers.
interface adc_scan_uart_tx_if #(
    parameter int CH_W   = 4,
    parameter int DATA_W = 8
);
    logic              eoc;
    logic [DATA_W-1:0] data_in;
    logic              dsr;
    logic              soc;
    logic              load_dato;
    logic              mux_en;
    logic [CH_W-1:0]   canale;
    logic              data_out;
    logic              error;
    logic              busy;
    logic [2:0]        scan_state;
    logic [1:0]        tx_state;

    modport master (
        input  eoc, data_in, dsr,
        output soc, load_dato, mux_en, canale, data_out, error, busy,
               scan_state, tx_state
    );

    modport slave (
        output eoc, data_in, dsr,
        input  soc, load_dato, mux_en, canale, data_out, error, busy,
               scan_state, tx_state
    );
endinterface

// File: rtl/adc_scan_uart_tx.sv
// adc_scan_uart_tx
// Scans an external analog mux over NUM_CH channels. For each channel it
// starts one ADC conversion and then sends the captured sample as an
// asynchronous serial frame, MSB first:
//   start bit (0), data bits, optional even parity, stop bit (1).
// Each bit lasts BIT_TICKS clocks.
// Ports:
//   clock   : system clock; all logic runs on its rising edge
//   reset_n : synchronous active-low reset
//   bus     : adc_scan_uart_tx_if.master
//             eoc/data_in/dsr in; soc/load_dato/mux_en/canale/data_out/
//             error/busy out; scan_state/tx_state are debug outputs
module adc_scan_uart_tx #(
    parameter int NUM_CH      = 8,
    parameter int CH_W        = 4,
    parameter int DATA_W      = 8,
    parameter int BIT_TICKS   = 105,
    parameter int PARITY_EN   = 0,
    parameter int EOC_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    adc_scan_uart_tx_if.master   bus
);
    localparam int NB     = DATA_W + 2 + PARITY_EN;  // bits per frame
    localparam int TICK_W = $clog2(BIT_TICKS);
    localparam int BIT_W  = $clog2(NB);
    localparam int TO_W   = $clog2(EOC_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_SOC    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_TX     = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_SHIFT = 2'd1;
    localparam logic [1:0] T_DONE  = 2'd2;

    logic [2:0]        scan_state_q, scan_state_d;
    logic [1:0]        tx_state_q, tx_state_d;
    logic [CH_W-1:0]   canale_q, canale_d;
    logic              soc_q, soc_d;
    logic              load_dato_q, load_dato_d;
    logic              mux_en_q, mux_en_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [NB-1:0]     shreg_q, shreg_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [NB-1:0]     frame;
    logic              tx_done;

    // Complete frame image, shifted out from the top bit downwards.
    if (PARITY_EN != 0) begin : g_par
        assign frame = {1'b0, sample_q, ^sample_q, 1'b1};
    end else begin : g_nopar
        assign frame = {1'b0, sample_q, 1'b1};
    end

    assign tx_done = (tx_state_q == T_DONE);

    always_comb begin
        scan_state_d = scan_state_q;
        tx_state_d   = tx_state_q;
        canale_d     = canale_q;
        soc_d        = 1'b0;
        load_dato_d  = 1'b0;
        mux_en_d     = mux_en_q;
        to_cnt_d     = to_cnt_q;
        sample_d     = sample_q;
        shreg_d      = shreg_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        data_out_d   = data_out_q;
        busy_d       = busy_q;
        error_d      = error_q;

        // Scan sequencer. Strobes are registered, so each is set one state
        // ahead of the state in which it is seen.
        case (scan_state_q)
            S_IDLE: begin
                scan_state_d = S_SETTLE;
                mux_en_d     = 1'b1;
            end
            S_SETTLE: begin
                scan_state_d = S_SOC;
                soc_d        = 1'b1;
            end
            S_SOC: begin
                scan_state_d = S_WAIT;
                to_cnt_d     = '0;
            end
            S_WAIT: begin
                // The timeout count saturates at EOC_TIMEOUT.
                if (to_cnt_q != TO_W'(EOC_TIMEOUT)) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (bus.eoc) begin
                    load_dato_d  = 1'b1;
                    sample_d     = bus.data_in;
                    mux_en_d     = 1'b0;
                    scan_state_d = S_TX;
                end else if (to_cnt_d == TO_W'(EOC_TIMEOUT)) begin
                    error_d      = 1'b1;
                    mux_en_d     = 1'b0;
                    scan_state_d = S_NEXT;
                end
            end
            S_TX: begin
                if (tx_done) begin
                    scan_state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                canale_d     = (canale_q == CH_W'(NUM_CH - 1)) ? '0 : canale_q + 1'b1;
                mux_en_d     = 1'b1;
                scan_state_d = S_SETTLE;
            end
            default: scan_state_d = S_IDLE;
        endcase

        // Transmitter. It starts on the cycle it first sees the scan FSM in
        // S_TX. At that moment the sample is already in sample_q.
        case (tx_state_q)
            T_IDLE: begin
                if (scan_state_q == S_TX) begin
                    if (bus.dsr) begin
                        error_d    = 1'b0;
                        busy_d     = 1'b1;
                        shreg_d    = frame;
                        data_out_d = frame[NB-1];
                        tick_d     = '0;
                        bit_d      = '0;
                        tx_state_d = T_SHIFT;
                    end else begin
                        // Receiver not ready: drop the frame and report it.
                        error_d    = 1'b1;
                        tx_state_d = T_DONE;
                    end
                end
            end
            T_SHIFT: begin
                if (tick_q == TICK_W'(BIT_TICKS - 1)) begin
                    tick_d = '0;
                    if (bit_q == BIT_W'(NB - 1)) begin
                        busy_d     = 1'b0;
                        data_out_d = 1'b1;
                        tx_state_d = T_DONE;
                    end else begin
                        bit_d      = bit_q + 1'b1;
                        shreg_d    = {shreg_q[NB-2:0], 1'b1};
                        data_out_d = shreg_q[NB-2];
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            T_DONE:  tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scan_state_q <= S_IDLE;
            tx_state_q   <= T_IDLE;
            canale_q     <= '0;
            soc_q        <= 1'b0;
            load_dato_q  <= 1'b0;
            mux_en_q     <= 1'b0;
            to_cnt_q     <= '0;
            sample_q     <= '0;
            shreg_q      <= '1;
            tick_q       <= '0;
            bit_q        <= '0;
            data_out_q   <= 1'b1;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            scan_state_q <= scan_state_d;
            tx_state_q   <= tx_state_d;
            canale_q     <= canale_d;
            soc_q        <= soc_d;
            load_dato_q  <= load_dato_d;
            mux_en_q     <= mux_en_d;
            to_cnt_q     <= to_cnt_d;
            sample_q     <= sample_d;
            shreg_q      <= shreg_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            data_out_q   <= data_out_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign bus.soc        = soc_q;
    assign bus.load_dato  = load_dato_q;
    assign bus.mux_en     = mux_en_q;
    assign bus.canale     = canale_q;
    assign bus.data_out   = data_out_q;
    assign bus.error      = error_q;
    assign bus.busy       = busy_q;
    assign bus.scan_state = scan_state_q;
    assign bus.tx_state   = tx_state_q;
endmodule

// File: tb/tb_adc_scan_uart_tx.sv
// Bench for adc_scan_uart_tx. There are two instances:
//   A: 3 channels, no parity
//   B: 5 channels, even parity
// Both use 8-bit samples, 4 clocks per bit and a 10-cycle eoc timeout.
// Only one instance is out of reset at a time. Its outputs are selected onto
// the *_w nets by sel.
module tb_adc_scan_uart_tx;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int BT    = 4;
    localparam int TO    = 10;
    localparam int NCH_A = 3;
    localparam int NCH_B = 5;

    // Clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a_n, rst_b_n;
    logic eoc, dsr;
    logic [DW-1:0] data_in;
    logic sel;

    adc_scan_uart_tx_if #(.CH_W(CW), .DATA_W(DW)) if_a ();
    adc_scan_uart_tx_if #(.CH_W(CW), .DATA_W(DW)) if_b ();

    assign if_a.eoc = eoc;
    assign if_a.data_in = data_in;
    assign if_a.dsr = dsr;
    assign if_b.eoc = eoc;
    assign if_b.data_in = data_in;
    assign if_b.dsr = dsr;

    adc_scan_uart_tx #(.NUM_CH(NCH_A), .CH_W(CW), .DATA_W(DW), .BIT_TICKS(BT),
                       .PARITY_EN(0), .EOC_TIMEOUT(TO))
        dut_a (.clock(clock), .reset_n(rst_a_n), .bus(if_a.master));

    adc_scan_uart_tx #(.NUM_CH(NCH_B), .CH_W(CW), .DATA_W(DW), .BIT_TICKS(BT),
                       .PARITY_EN(1), .EOC_TIMEOUT(TO))
        dut_b (.clock(clock), .reset_n(rst_b_n), .bus(if_b.master));

    logic soc_w, load_w, mux_w, dout_w, err_w, busy_w;
    logic [CW-1:0] canale_w;
    assign soc_w    = sel ? if_b.soc       : if_a.soc;
    assign load_w   = sel ? if_b.load_dato : if_a.load_dato;
    assign mux_w    = sel ? if_b.mux_en    : if_a.mux_en;
    assign dout_w   = sel ? if_b.data_out  : if_a.data_out;
    assign err_w    = sel ? if_b.error     : if_a.error;
    assign busy_w   = sel ? if_b.busy      : if_a.busy;
    assign canale_w = sel ? if_b.canale    : if_a.canale;

    // Scoreboard / reference model state
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_ch;
    logic exp_err;
    int   num_ch;
    int   par_en;
    logic [DW-1:0] exp_q[$];   // samples expected to be sent, in order

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Driver tasks
    task automatic check_reset_state(input string tag);
        check({tag, "_soc"},    16'(soc_w),    16'(0));
        check({tag, "_load"},   16'(load_w),   16'(0));
        check({tag, "_mux"},    16'(mux_w),    16'(0));
        check({tag, "_canale"}, 16'(canale_w), 16'(0));
        check({tag, "_dout"},   16'(dout_w),   16'(1));
        check({tag, "_err"},    16'(err_w),    16'(0));
        check({tag, "_busy"},   16'(busy_w),   16'(0));
    endtask

    task automatic wait_soc();
        int n = 0;
        do begin
            step();
            n++;
        end while (soc_w !== 1'b1 && n < 30);
        check("soc_seen", 16'(soc_w), 16'(1));
        check("canale", 16'(canale_w), 16'(exp_ch));
        check("mux_at_soc", 16'(mux_w), 16'(1));
        check("soc_load_excl", 16'(load_w), 16'(0));
    endtask

    // Waits for soc, answers after 'delay' cycles and returns in the load_dato cycle.
    task automatic convert(input logic [DW-1:0] data, input int delay, input logic dsr_v);
        wait_soc();
        dsr = dsr_v;
        data_in = data;
        for (int i = 1; i < delay; i++) begin
            step();
            check("no_early_load", 16'(load_w), 16'(0));
        end
        step();
        eoc = 1'b1;
        check("mux_before_load", 16'(mux_w), 16'(1));
        step();
        eoc = 1'b0;
        check("load_strobe", 16'(load_w), 16'(1));
        check("load_no_soc", 16'(soc_w), 16'(0));
        check("mux_off_at_load", 16'(mux_w), 16'(0));
        exp_q.push_back(data);
    endtask

    // Expected line sequence, one entry per bit: start bit, data bits MSB
    // first, even parity, stop bit.
    task automatic frame_bits(input logic [DW-1:0] data, output logic bits[$]);
        int ones = 0;
        bits = {};
        bits.push_back(1'b0);
        for (int i = DW - 1; i >= 0; i--) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (par_en != 0) bits.push_back(1'((ones % 2) != 0));
        bits.push_back(1'b1);
    endtask

    task automatic conv_good(input logic [DW-1:0] data, input int delay, input logic dsr_v);
        logic          bits[$];
        logic [DW-1:0] sent;
        int            cyc;
        int            bad;
        convert(data, delay, dsr_v);
        sent = exp_q.pop_front();
        step();
        if (dsr_v) begin
            frame_bits(sent, bits);
            check("err_clear_at_start", 16'(err_w), 16'(0));
            cyc = 0;
            bad = 0;
            while (busy_w === 1'b1 && cyc < 200) begin
                if ((cyc / BT) >= bits.size() || dout_w !== bits[cyc / BT]) bad++;
                if (err_w !== 1'b0) bad++;
                cyc++;
                step();
            end
            check("frame_bits_bad", 16'(bad), 16'(0));
            check("busy_len", 16'(cyc), 16'((DW + 2 + par_en) * BT));
            check("idle_after_stop", 16'(dout_w), 16'(1));
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                check("drop_err", 16'(err_w), 16'(1));
                check("drop_busy", 16'(busy_w), 16'(0));
                check("drop_line", 16'(dout_w), 16'(1));
                if (i == 0) step();
            end
            exp_err = 1'b1;
        end
        exp_ch = (exp_ch + 1) % num_ch;
    endtask

    task automatic conv_timeout();
        wait_soc();
        eoc = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            step();
            check("to_no_load", 16'(load_w), 16'(0));
            check("to_err_hold", 16'(err_w), 16'(exp_err));
        end
        step();
        check("to_err_set", 16'(err_w), 16'(1));
        check("to_no_load_end", 16'(load_w), 16'(0));
        exp_err = 1'b1;
        exp_ch = (exp_ch + 1) % num_ch;
    endtask

    task automatic conv_reset_mid(input logic [DW-1:0] data);
        convert(data, 2, 1'b1);
        void'(exp_q.pop_front());
        // Move into the slot of data bit 3 (slot 4, counting the start bit as slot 0).
        for (int i = 0; i < 4 * BT + 2; i++) step();
        check("mid_busy", 16'(busy_w), 16'(1));
        if (sel) rst_b_n = 1'b0; else rst_a_n = 1'b0;
        step();
        check_reset_state("mid_rst");
        if (sel) rst_b_n = 1'b1; else rst_a_n = 1'b1;
        exp_ch = 0;
        exp_err = 1'b0;
    endtask

    task automatic random_runs(input int n);
        for (int r = 0; r < n; r++) begin
            int kind = $urandom_range(7, 0);
            logic [DW-1:0] d = DW'($urandom);
            int dly = $urandom_range(TO, 1);
            if (kind == 0) conv_timeout();
            else conv_good(d, dly, kind != 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        eoc = 1'b0;
        dsr = 1'b1;
        data_in = '0;
        step();
        step();
        check_reset_state("rst_a");

        // Instance A: 3 channels, no parity
        num_ch = NCH_A;
        par_en = 0;
        exp_ch = 0;
        exp_err = 1'b0;
        rst_a_n = 1'b1;
        conv_good(8'hA5, 3, 1'b1);
        conv_good(8'h3C, 1, 1'b1);
        conv_good(8'hFF, TO, 1'b1);
        conv_good(8'h00, 5, 1'b1);                 // back on channel 0
        conv_timeout();
        conv_good(8'h5A, 4, 1'b1);                 // clears error
        conv_good(8'h81, 2, 1'b0);                 // receiver not ready
        conv_timeout();                            // error stays set
        conv_good(DW'($urandom), 3, 1'b1);
        random_runs(8);
        conv_reset_mid(8'hC3);
        conv_good(8'h96, 3, 1'b1);

        // Instance B: 5 channels, even parity
        rst_a_n = 1'b0;
        sel = 1'b1;
        step();
        check_reset_state("rst_b");
        num_ch = NCH_B;
        par_en = 1;
        exp_ch = 0;
        exp_err = 1'b0;
        rst_b_n = 1'b1;
        conv_good(8'h07, 2, 1'b1);
        conv_good(8'hA5, 3, 1'b1);
        conv_good(8'h01, 6, 1'b1);
        conv_timeout();
        conv_good(8'hFE, 1, 1'b1);
        conv_good(8'h10, 2, 1'b1);                 // wraps 4 -> 0
        random_runs(8);
        conv_reset_mid(8'h7E);
        conv_good(8'h33, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
